// File: rtl/fft_pingpong_mem.sv
// fft_pingpong_mem: self-sequencing ping-pong bank storage and twiddle ROM for a radix-2 DIT FFT
// Ports: i_start/i_load_* take N natural-order samples (o_load_ready while loading);
// o_even/o_odd/o_twi with o_bfly_valid present butterfly operands; i_wb_valid with i_top/i_bot
// return results in issue order; o_out_* with o_out_index/o_out_valid/o_done stream the spectrum;
// o_stage, o_busy and the sticky o_err report progress and protocol violations.
module fft_pingpong_mem #(
  parameter int N = 8,
  parameter int I = 4,
  parameter int F = 12,
  localparam int W = I + F,
  localparam int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_load_valid,
  input  logic [W-1:0]    i_load_re,
  input  logic [W-1:0]    i_load_im,
  output logic            o_load_ready,
  output logic [W-1:0]    o_even_re,
  output logic [W-1:0]    o_even_im,
  output logic [W-1:0]    o_odd_re,
  output logic [W-1:0]    o_odd_im,
  output logic [W-1:0]    o_twi_re,
  output logic [W-1:0]    o_twi_im,
  output logic            o_bfly_valid,
  input  logic            i_wb_valid,
  input  logic [W-1:0]    i_top_re,
  input  logic [W-1:0]    i_top_im,
  input  logic [W-1:0]    i_bot_re,
  input  logic [W-1:0]    i_bot_im,
  output logic [W-1:0]    o_out_re,
  output logic [W-1:0]    o_out_im,
  output logic [LOGN-1:0] o_out_index,
  output logic            o_out_valid,
  output logic [LOGN-1:0] o_stage,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_STAGE = 2'd2, S_UNLD = 2'd3;
  localparam int TB = LOGN - 1;
  localparam logic [LOGN-1:0] HALF = LOGN'(N / 2);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
  localparam logic [LOGN-1:0] SLAST = LOGN'(LOGN - 1);

  function automatic logic [N*W-1:0] mk_rom();
    logic [N*W-1:0] r;
    real a;
    r = '0;
    for (int m = 0; m < N / 2; m++) begin
      a = 2.0 * 3.14159265358979323846 * m / N;
      r[m*2*W +: 2*W] = {W'(int'($cos(a) * (2.0 ** F))), W'(int'(-$sin(a) * (2.0 ** F)))};
    end
    return r;
  endfunction

  localparam logic [N*W-1:0] ROM = mk_rom();

  // even address of butterfly k in stage s: insert a zero at bit s of k
  function automatic logic [LOGN-1:0] ev_addr(input logic [LOGN-1:0] k, input logic [LOGN-1:0] s);
    logic [LOGN-1:0] m;
    m = (LOGN'(1) << s) - LOGN'(1);
    return ((k >> s) << (s + LOGN'(1))) | (k & m);
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = x[LOGN-1-b];
    return r;
  endfunction

  logic [1:0]      st_q, st_d, rv_q;
  logic [LOGN-1:0] cnt_q, k_rd_q, k_wr_q, stage_q, bot_addr_q, un_idx_q, out_idx_q;
  logic [LOGN-1:0] raddr, wa, ev_rd, ev_wr, hbit;
  logic [TB-1:0]   tw_q, tw_idx;
  logic            ph_q, src_q, bot_pend_q, un_v_q, bfly_v_q, out_v_q, done_q, err_q;
  logic [2*W-1:0]  bank_a [N];
  logic [2*W-1:0]  bank_b [N];
  logic [2*W-1:0]  ra_q, rb_q, rd, wd, bot_q, ev_hold_q, even_q, odd_q, twi_q, out_q;
  logic            issue, ld_acc, acc, wb_err, stg_end, busy, start_ok, we_a, we_b;

  always_comb begin
    hbit = LOGN'(1) << stage_q;
    ev_rd = ev_addr(k_rd_q, stage_q);
    ev_wr = ev_addr(k_wr_q, stage_q);
    issue = st_q == S_STAGE && k_rd_q != HALF;
    tw_idx = TB'((k_rd_q & (hbit - LOGN'(1))) << (SLAST - stage_q));
    raddr = st_q == S_UNLD ? cnt_q : (ph_q ? ev_rd | hbit : ev_rd);
    rd = src_q ? rb_q : ra_q;
    ld_acc = st_q == S_LOAD && i_load_valid;
    // one writeback per two cycles: the cycle after an accept is reserved for the held bot write
    acc = i_wb_valid && st_q == S_STAGE && k_wr_q != HALF && !bot_pend_q;
    wb_err = i_wb_valid && !acc;
    stg_end = st_q == S_STAGE && k_rd_q == HALF && k_wr_q == HALF && bot_pend_q;
    // the output pipeline still drains for two cycles after the last unload read
    busy = st_q != S_IDLE || un_v_q || out_v_q;
    start_ok = i_start && !busy;
    wa = ld_acc ? bitrev(cnt_q) : (acc ? ev_wr : bot_addr_q);
    wd = ld_acc ? {i_load_re, i_load_im} : (acc ? {i_top_re, i_top_im} : bot_q);
    we_a = !rst && (ld_acc || ((acc || bot_pend_q) && src_q));
    we_b = !rst && (acc || bot_pend_q) && !src_q;
    st_d = start_ok ? S_LOAD :
           (ld_acc && cnt_q == LAST) ? S_STAGE :
           (stg_end && stage_q == SLAST) ? S_UNLD :
           (st_q == S_UNLD && cnt_q == LAST) ? S_IDLE : st_q;
  end

  always_ff @(posedge clk) begin
    if (we_a) bank_a[wa] <= wd;
    if (we_b) bank_b[wa] <= wd;
    ra_q <= bank_a[raddr];
    rb_q <= bank_b[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      k_rd_q <= '0;
      k_wr_q <= '0;
      stage_q <= '0;
      ph_q <= 1'b0;
      src_q <= 1'b0;
      bot_pend_q <= 1'b0;
      bot_q <= '0;
      bot_addr_q <= '0;
      rv_q <= '0;
      tw_q <= '0;
      ev_hold_q <= '0;
      bfly_v_q <= 1'b0;
      even_q <= '0;
      odd_q <= '0;
      twi_q <= '0;
      un_v_q <= 1'b0;
      un_idx_q <= '0;
      out_v_q <= 1'b0;
      out_q <= '0;
      out_idx_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_q + LOGN'(ld_acc || st_q == S_UNLD);
      k_rd_q <= stg_end ? '0 : k_rd_q + LOGN'(issue && ph_q);
      ph_q <= ph_q ^ issue;
      k_wr_q <= stg_end ? '0 : k_wr_q + LOGN'(acc);
      stage_q <= st_q == S_LOAD ? '0 : stage_q + LOGN'(stg_end && stage_q != SLAST);
      src_q <= st_q == S_LOAD ? 1'b0 : src_q ^ stg_end;
      bot_pend_q <= acc;
      if (acc) begin
        bot_q <= {i_bot_re, i_bot_im};
        bot_addr_q <= ev_wr | hbit;
      end
      rv_q <= {rv_q[0], issue && !ph_q};
      if (issue && !ph_q) tw_q <= tw_idx;
      if (rv_q[0]) ev_hold_q <= rd;
      bfly_v_q <= rv_q[1];
      if (rv_q[1]) begin
        even_q <= ev_hold_q;
        odd_q <= rd;
        twi_q <= ROM[int'(tw_q)*2*W +: 2*W];
      end
      un_v_q <= st_q == S_UNLD;
      un_idx_q <= cnt_q;
      out_v_q <= un_v_q;
      if (un_v_q) begin
        out_q <= rd;
        out_idx_q <= un_idx_q;
      end
      done_q <= un_v_q && un_idx_q == LAST;
      err_q <= !start_ok && (err_q || wb_err);
    end
  end

  assign o_load_ready = st_q == S_LOAD;
  assign {o_even_re, o_even_im} = even_q;
  assign {o_odd_re, o_odd_im} = odd_q;
  assign {o_twi_re, o_twi_im} = twi_q;
  assign o_bfly_valid = bfly_v_q;
  assign {o_out_re, o_out_im} = out_q;
  assign o_out_index = out_idx_q;
  assign o_out_valid = out_v_q;
  assign o_stage = stage_q;
  assign o_busy = busy;
  assign o_done = done_q;
  assign o_err = err_q;
endmodule

// File: doc/fft_pingpong_mem.md
# fft_pingpong_mem

Self-sequencing ping-pong storage for the radix-2 DIT FFT datapath: two complex banks of N words plus an internal twiddle ROM. It accepts N natural-order samples and stores them bit-reversed. It then drives log2(N) stages of butterfly operand pairs to the external butterfly, writes results back to the opposite bank, and streams the final spectrum out in natural order. It replaces host-driven address and mux control with internal counters and a state machine.

## Interface
- N, default 8: FFT points; power of 2, ≥ 4. LOGN = $clog2(N).
- I, default 4: integer bits of signed fixed-point words.
- F, default 12: fractional bits; word width W = I+F.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_start  in  1  begin a transform; honoured only in IDLE.
- i_load_valid  in  1  load sample present.
- i_load_re / i_load_im  in  W  load sample, natural order.
- o_load_ready  out  1  high in LOAD.
- o_even_re / o_even_im / o_odd_re / o_odd_im  out  W  butterfly operands.
- o_twi_re / o_twi_im  out  W  twiddle aligned with operands.
- o_bfly_valid  out  1  one-cycle pulse; operands and twiddle valid.
- i_wb_valid  in  1  butterfly result present.
- i_top_re / i_top_im / i_bot_re / i_bot_im  in  W  butterfly results.
- o_out_re / o_out_im  out  W  result sample.
- o_out_index  out  LOGN  natural-order index of o_out_*.
- o_out_valid  out  1  result sample valid.
- o_stage  out  LOGN  current stage, 0..LOGN-1.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse with the last o_out_valid.
- o_err  out  1  sticky protocol error; cleared by rst or accepted i_start.

## Operation
- Banks A and B: each one write port and one registered read port, complex W-bit. Contents are not cleared by rst.
- Twiddle ROM: N/2 entries. Entry m = round(cos(2πm/N)·2^F), −round(sin(2πm/N)·2^F), signed Q(I.F).
- States: IDLE → LOAD (on i_start) → STAGE → UNLOAD → IDLE.
- LOAD:
  - Each cycle with i_load_valid=1 writes bank A at bitrev(n), where n counts 0..N-1.
  - Gaps in i_load_valid are allowed.
  - After the N-th accept, go to STAGE with o_stage=0, src=A, dst=B.
- STAGE s, with h = 2^s:
  - Butterfly k = 0..N/2-1; pos = k mod h; even = ((k>>s)<<(s+1)) + pos; odd = even + h; twiddle index = pos << (LOGN-1-s).
  - Read issue counter k_rd: even address in one cycle, odd address the next. One butterfly per 2 cycles, back-to-back until k_rd = N/2.
  - Writeback counter k_wr regenerates the same address sequence in order. The external butterfly returns results in issue order, at any latency.
  - On an accepted i_wb_valid: write top to dst[even(k_wr)] that cycle; hold bot and write it to dst[odd(k_wr)] the next cycle; increment k_wr.
  - Stage ends when k_rd = N/2, k_wr = N/2, and the held bot write is complete. Then swap src/dst and increment s.
  - After stage LOGN-1, go to UNLOAD.
- UNLOAD:
  - Read the final bank (A if LOGN even, else B) at addresses 0..N-1, one per cycle.
  - Last read → IDLE; o_done pulses with the N-th o_out_valid.
- Errors: set o_err and ignore the input, with no write, when any of the following occurs:
  - i_wb_valid outside STAGE.
  - i_wb_valid after N/2 results in the current stage.
  - i_wb_valid in the cycle immediately after an accepted wb.
- i_start outside IDLE is ignored and is not an error.

## Timing
- Reset: state IDLE; all counters, o_stage, and all data outputs = 0; o_load_ready, o_bfly_valid, o_out_valid, o_busy, o_done, o_err = 0.
- Reset mid-operation: abort at the next edge and discard in-flight reads and writebacks. The next i_start runs a full transform correctly.
- i_start is accepted at edge e. o_load_ready and o_busy are high from e+1.
- First read issue: the cycle after entering STAGE.
- o_bfly_valid for an even issued in cycle t: asserted in cycle t+3. All operand and twiddle outputs are registered and hold until the next pulse.
- Earliest wb acceptance: the cycle after the corresponding o_bfly_valid. Minimum wb spacing: 2 cycles.
- Stage-to-stage gap: the first read of stage s+1 issues the cycle after the final bot write of stage s completes.
- UNLOAD: o_out_valid 2 cycles after each address issue, then N consecutive valid cycles. o_busy falls the cycle after o_done.

## Test plan
- Stage-0 operands: N=8, I=4, F=12; load re = n·4096, im = 0. Required stage-0 pairs in order: (0,4), (2,6), (1,5), (3,7) ×4096, each with twiddle (4096, 0).
- Loopback, stage 2: external butterfly returns top=even, bot=odd with 1-cycle latency. Required stage-2 twiddles in order: (4096,0), (2896,−2896), (0,−4096), (−2896,−2896).
- Loopback, unload: same setup as above. Required o_out_re/4096 for index 0..7: 0,4,2,6,1,5,3,7. o_done coincides with index 7.
- Load gaps: i_load_valid toggled every other cycle with the same data. Required: identical unload output; o_load_ready stays high until the 8th accept.
- Protocol errors: i_wb_valid on two consecutive cycles → o_err=1 and the second write is dropped; i_wb_valid in IDLE → o_err=1. i_start then clears o_err.
- Reset mid-run: assert rst during stage 1 → the next cycle shows IDLE with all outputs 0. A following full transform matches the loopback result.
